// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit to 2x16-bit SRAM controller:
// FSM states, default data-memory base and strobe bit positions.
package sram_controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int unsigned DATA_MEM_BASE = 1024;

  // Positions inside sramCtrl = {WE_N, OE_N, CE_N, UB_N, LB_N}
  localparam int WE_N = 4;
  localparam int OE_N = 3;
  localparam int CE_N = 2;
  localparam int UB_N = 1;
  localparam int LB_N = 0;

  // Word index of a byte address; upper bits drop so accesses wrap every 2^17 words.
  function automatic logic [16:0] toWordAddr(input logic [31:0] byteAddr,
                                             input logic [31:0] base);
    return 17'((byteAddr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses, holding ready
// low for the whole transaction and pulsing it in DONE.
//
// state | meaning
// IDLE  | waiting; ready follows !(rdEn|wrEn), request latched on the edge
// RD_LO | reading low half-word, captured on the last phase cycle
// RD_HI | reading high half-word, captured on the last phase cycle
// WR_LO | driving writeData[15:0] with WE_N low
// WR_HI | driving writeData[31:16] with WE_N low
// DONE  | strobes released, ready high for one cycle
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned DATA_MEM_BASE    = sram_controller_pkg::DATA_MEM_BASE,
  parameter int unsigned SRAM_WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] sramData,
  output logic [17:0] sramAddress,
  output logic [4:0]  sramCtrl
);

  localparam int CW = (SRAM_WAIT_CYCLES > 1) ? $clog2(SRAM_WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SRAM_WAIT_CYCLES - 1);

  state_t      state, stateNext;
  logic [CW-1:0] phaseCnt;
  logic        loadCnt;
  logic        lastCycle;
  logic [16:0] wordAddr;
  logic [31:0] wrDataLat;
  logic        driveBus;
  logic [15:0] busOut;
  logic        request;

  assign request   = rdEn | wrEn;
  assign lastCycle = (phaseCnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phaseCnt  <= '0;
      wordAddr  <= '0;
      wrDataLat <= '0;
      readData  <= '0;
    end else begin
      state <= stateNext;
      if (loadCnt)
        phaseCnt <= RELOAD;
      else if (phaseCnt != '0)
        phaseCnt <= phaseCnt - 1'b1;
      if (state == IDLE && request) begin
        wordAddr  <= toWordAddr(address, 32'(DATA_MEM_BASE));
        wrDataLat <= writeData;
      end
      if (state == RD_LO && lastCycle) readData[15:0]  <= sramData;
      if (state == RD_HI && lastCycle) readData[31:16] <= sramData;
    end
  end

  always_comb begin
    stateNext   = state;
    loadCnt     = 1'b0;
    ready       = 1'b0;
    sramCtrl    = 5'b11111;
    sramAddress = '0;
    driveBus    = 1'b0;
    busOut      = '0;
    unique case (state)
      IDLE: begin
        ready = ~request;
        if (wrEn) begin
          stateNext = WR_LO;
          loadCnt   = 1'b1;
        end else if (rdEn) begin
          stateNext = RD_LO;
          loadCnt   = 1'b1;
        end
      end
      RD_LO, RD_HI: begin
        sramCtrl[CE_N] = 1'b0;
        sramCtrl[OE_N] = 1'b0;
        sramCtrl[UB_N] = 1'b0;
        sramCtrl[LB_N] = 1'b0;
        sramAddress    = {wordAddr, (state == RD_HI)};
        if (lastCycle) begin
          stateNext = (state == RD_LO) ? RD_HI : DONE;
          loadCnt   = (state == RD_LO);
        end
      end
      WR_LO, WR_HI: begin
        sramCtrl[CE_N] = 1'b0;
        sramCtrl[WE_N] = 1'b0;
        sramCtrl[UB_N] = 1'b0;
        sramCtrl[LB_N] = 1'b0;
        sramAddress    = {wordAddr, (state == WR_HI)};
        driveBus       = 1'b1;
        busOut         = (state == WR_HI) ? wrDataLat[31:16] : wrDataLat[15:0];
        if (lastCycle) begin
          stateNext = (state == WR_LO) ? WR_HI : DONE;
          loadCnt   = (state == WR_LO);
        end
      end
      DONE: begin
        ready     = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Only write states drive the bus, and they always hold OE_N high.
  assign sramData = driveBus ? busOut : 16'bz;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits directly downstream of the MEM stage and is the only block that touches the external 16-bit SRAM.
- Converts one 32-bit data-memory load or store into two sequential 16-bit SRAM accesses.
- Drops `ready` for the whole transaction so the pipeline freezes, then pulses `ready` for one cycle when the transaction completes.

Parameters:
- DATA_MEM_BASE, 1024: byte address mapped to SRAM location 0.
- SRAM_WAIT_CYCLES, 2: cycles each 16-bit half-access is held (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wrEn  in  1  store request from MEM stage.
- rdEn  in  1  load request from MEM stage.
- address  in  32  byte address (ALU result).
- writeData  in  32  store value.
- readData  out  32  load result, registered.
- ready  out  1  0 = transaction in progress (freeze pipeline).
- sramData  inout  16  SRAM data bus.
- sramAddress  out  18  SRAM half-word address.
- sramCtrl  out  5  active-low strobes: {WE_N, OE_N, CE_N, UB_N, LB_N}.

Behaviour:
- Reset (async, immediate):
  - State is IDLE; readData=0; sramAddress=0; sramCtrl=5'b11111.
  - sramData is high-Z; internal counters are 0.
- Address mapping:
  - wordAddr = (address - DATA_MEM_BASE) >> 2, keep bits [16:0].
  - Low half is at {wordAddr,1'b0}; high half is at {wordAddr,1'b1}.
  - Bits above [16:0] are discarded, so addresses wrap modulo 2^17 words.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE:
  - `ready` is 1 combinationally unless rdEn or wrEn is high.
  - If a request is present, `ready` drops in that same cycle (cycle 0).
  - address and writeData are latched into internal registers at the cycle-0 edge.
  - Next state: WR_LO if wrEn is high, else RD_LO. wrEn wins if both are high.
- Phase timing:
  - Each *_LO / *_HI phase lasts exactly SRAM_WAIT_CYCLES cycles, using a down-counter reloaded on phase entry.
  - Transitions: LO → HI → DONE.
- Read phases:
  - Control: CE_N=0, OE_N=0, UB_N=LB_N=0, WE_N=1; sramData is high-Z.
  - Capture into readData on the last cycle of each phase: [15:0] in RD_LO, [31:16] in RD_HI.
- Write phases:
  - Control: CE_N=0, WE_N=0, UB_N=LB_N=0, OE_N=1.
  - sramData drives latched writeData[15:0] in WR_LO and [31:16] in WR_HI.
  - WE_N returns to 1 in DONE; the data bus releases in the same cycle.
- DONE:
  - `ready`=1 for exactly one cycle; readData holds the new value.
  - Next state is IDLE, which re-evaluates rdEn/wrEn the following cycle.
  - The pipeline advances on the DONE edge, so there is no double issue.
- Latency:
  - `ready` is low for 2*SRAM_WAIT_CYCLES+1 cycles, counting from cycle 0.
  - DONE occurs at cycle 2*SRAM_WAIT_CYCLES+1 (cycle 5 with default W=2).
- Request stability:
  - Deassertion of rdEn/wrEn mid-transaction is ignored; the latched operation completes.
  - Changes to address/writeData after cycle 0 have no effect.
- readData holds its value across writes and idle cycles until the next read completes.
- Reset mid-transaction aborts immediately:
  - WE_N=1 and the bus releases in the same cycle.
  - Partial read data is discarded; readData=0.
- Back-to-back requests: a new request seen in IDLE right after DONE starts a fresh transaction with no bubble beyond the DONE cycle.
- Bus contention: the controller never drives sramData while OE_N=0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE);
  - DATA_MEM_BASE;
  - sramCtrl bit-index constants (WE_N=4, OE_N=3, CE_N=2, UB_N=1, LB_N=0).
- Single module. The phase counter and tri-state driver are inline; no sub-module is warranted.
- The bench provides a behavioural 256K×16 SRAM model with registered read data.

Test Plan:
- Reset then idle, rdEn=wrEn=0 → ready=1, sramCtrl=5'b11111, sramData=Z, readData=0.
- Store:
  - Stimulus: wrEn=1, address=1024, writeData=32'hDEADBEEF, W=2.
  - Response: ready low cycles 0–4 and high at cycle 5.
  - Response: SRAM[0]=16'hBEEF, SRAM[1]=16'hDEAD; WE_N low only in cycles 1–4.
- Load after the store:
  - Stimulus: rdEn=1, address=1024.
  - Response: readData=32'hDEADBEEF at cycle 5; OE_N low in cycles 1–4; sramData never driven.
- Address wrap: store 32'h12345678 to address=1024+4*(2^17)+8 → lands at SRAM[4] and SRAM[5].
- Simultaneous request:
  - Stimulus: rdEn=wrEn=1, writeData=32'h0000CAFE, address=1032.
  - Response: a write is performed; readData is unchanged from its previous value.
- Reset mid-write:
  - Stimulus: assert rst in cycle 2 of a store.
  - Response: WE_N=1 and sramData=Z in the same cycle; state is IDLE, ready=1, readData=0.
- Request glitch:
  - Stimulus: drop rdEn and change address in cycle 1.
  - Response: the transaction completes at cycle 5 using the cycle-0 address.
